traffic_sensor_conditioner: RTL and testbench
=============================================

# traffic_sensor_conditioner

- Conditions the two raw vehicle-detector inputs (road A, road B) before they reach the traffic controller as `Sa`/`Sb`.
- Per channel: 2-flop synchronization, counter-based debounce, and an optional sticky-request mode.
- The sticky request is held until the controller grants green to that road.
- A saturating per-channel vehicle-arrival counter is also kept for diagnostics.
- Sits directly upstream of `traffic_controller` inside the controller top level.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16, consecutive stable cycles required to accept a level change; legal range 2..65535.
- `LATCH_MODE`, 0, 0 = outputs follow debounced level; 1 = outputs are sticky requests.
- `COUNT_W`, 8, width of arrival counters.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sa_raw`  in  1  raw detector A, asynchronous to `clk`.
- `sb_raw`  in  1  raw detector B, asynchronous to `clk`.
- `clear_a`  in  1  request clear for A; wired to controller `Ga`.
- `clear_b`  in  1  request clear for B; wired to controller `Gb`.
- `Sa`  out  1  conditioned sensor A to controller.
- `Sb`  out  1  conditioned sensor B to controller.
- `count_a`  out  `COUNT_W`  debounced rising edges seen on A, saturating.
- `count_b`  out  `COUNT_W`  debounced rising edges seen on B, saturating.

## Operation
Each channel is independent and identical.

Synchronizer:
- `sync1 <= raw`, `sync2 <= sync1`.
- Both flops reset to 0.

Debounce:
- State is `stable` (reset 0) and `cnt` (width `$clog2(DEBOUNCE_CYCLES)`, reset 0).
- `sync2 == stable`: `cnt <= 0`.
- `sync2 != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync2`, `cnt <= 0`.
- `sync2 != stable` otherwise: `cnt <= cnt+1`.
- A pulse or glitch shorter than `DEBOUNCE_CYCLES` cycles at `sync2` is discarded: `cnt` returns to 0 and `stable` is unchanged.

Rise event:
- `rise` is a combinational signal, true on the cycle `stable` is about to update 0→1.
- On that same edge the effect is registered (request set, counter increment).

Output, `LATCH_MODE=0`:
- `S = stable`; `clear_x` is ignored.

Output, `LATCH_MODE=1`:
- `req <= (req | rise) & ~clear`; reset 0; `S = req`.
- Clear wins when clear and rise coincide. The road is already green, so the demand is served.
- A falling `stable` never clears `req`; only `clear` does.

Counter:
- `count <= count + 1` on `rise` when `count != all-ones`.
- At all-ones the counter holds.
- Only reset zeroes it.

Reset:
- Asynchronous assert mid-debounce aborts the debounce and zeroes all state.
- All outputs are 0 while `reset_n` is low.
- After deassertion, the first sample is taken on the next rising edge.

## Timing
Reset values:
- `Sa = Sb = 0`.
- `count_a = count_b = 0`.
- All internal flops 0.

Latency:
- Raw level change (held stable) to `S` change is `DEBOUNCE_CYCLES+2` clock edges, counting the first edge that samples the new raw value.
- With the default, 18 edges.
- The same latency applies in both modes and for the counter.

Other timing rules:
- `clear` acts on the next edge: `S` falls one cycle after `clear` is first sampled high.
- No combinational path from any input to any output; all outputs are flop outputs.
- Channels never interact; simultaneous events on A and B are handled independently in the same cycle.

## Structure
Shared package `traffic_pkg` holds:
- `DEBOUNCE_DEFAULT` = 16;
- `COUNT_W_DEFAULT` = 8;
- `LATCH_LEVEL`/`LATCH_STICKY` encodings (0/1).

Sub-module `sensor_debounce` (sync + debounce + rise + req + counter for one channel):
- Instantiated twice.
- Parameters are passed through.

The top level is only instantiation and wiring.

## Test plan
- Reset, `DEBOUNCE_CYCLES=16`, `LATCH_MODE=0`: hold `sa_raw=1` from edge 0 → `Sa` rises after exactly 18 edges, `count_a=1`, `Sb`/`count_b` remain 0.
- Glitch rejection: `sb_raw` high for 15 cycles, low 5, high 16 → `Sb` stays 0 through the glitch and rises 18 edges after the final rise; `count_b=1`.
- Sticky mode, `LATCH_MODE=1`:
  - `sa_raw` pulse of 20 cycles → `Sa` rises 18 edges in, stays 1 after `sa_raw` drops.
  - `clear_a` pulsed 1 cycle → `Sa=0` on the next edge.
- Clear/rise collision: assert `clear_a` on the exact cycle `rise` occurs → `Sa` stays 0 and `count_a` still increments.
- Saturation, `COUNT_W=8`: 260 debounced pulses on A → `count_a` reaches 255 and holds.
- Reset mid-operation: assert `reset_n=0` at cnt=10 during a rising debounce → all outputs 0 immediately (asynchronous).
  - After release with raw still high, `Sa` rises 18 edges after the first post-reset edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared constants for the traffic controller slice: sensor conditioning defaults and
// the output-mode encodings used by the detector front end.
package traffic_pkg;

  localparam int unsigned DEBOUNCE_DEFAULT = 16;
  localparam int unsigned COUNT_W_DEFAULT  = 8;

  localparam int unsigned LATCH_LEVEL  = 0;
  localparam int unsigned LATCH_STICKY = 1;

endpackage

// File: rtl/sensor_debounce.sv
// One detector channel: 2-flop synchronizer, counter debounce, rise detect,
// optional sticky request and a saturating arrival counter.
module sensor_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LATCH_MODE      = LATCH_LEVEL,
  parameter int unsigned COUNT_W         = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               raw_i,
  input  logic               clear_i,
  output logic               s_o,
  output logic [COUNT_W-1:0] count_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic               sync1_q, sync2_q;
  logic               stable_q;
  logic [CntW-1:0]    cnt_q;
  logic               req_q;
  logic [COUNT_W-1:0] count_q;
  logic               differ, at_max, rise;

  always_comb begin
    differ = sync2_q != stable_q;
    at_max = cnt_q == CntMax;
    // Only a change towards 1 that completes its debounce window counts as an arrival.
    rise   = differ & at_max & sync2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      if (!differ) begin
        cnt_q <= '0;
      end else if (at_max) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
      // Clear wins over a coincident rise: the road is already green.
      req_q <= (req_q | rise) & ~clear_i;
      if (rise && (count_q != '1)) begin
        count_q <= count_q + COUNT_W'(1);
      end
    end
  end

  assign s_o     = (LATCH_MODE == LATCH_STICKY) ? req_q : stable_q;
  assign count_o = count_q;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw road A/B vehicle detectors into Sa/Sb for the traffic controller;
// two independent sensor_debounce channels, wiring only.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int unsigned LATCH_MODE      = LATCH_LEVEL,
  parameter int unsigned COUNT_W         = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sa_raw,
  input  logic               sb_raw,
  input  logic               clear_a,
  input  logic               clear_b,
  output logic               Sa,
  output logic               Sb,
  output logic [COUNT_W-1:0] count_a,
  output logic [COUNT_W-1:0] count_b
);

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LATCH_MODE     (LATCH_MODE),
    .COUNT_W        (COUNT_W)
  ) u_chan_a (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (sa_raw),
    .clear_i(clear_a),
    .s_o    (Sa),
    .count_o(count_a)
  );

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LATCH_MODE     (LATCH_MODE),
    .COUNT_W        (COUNT_W)
  ) u_chan_b (
    .clk    (clk),
    .reset_n(reset_n),
    .raw_i  (sb_raw),
    .clear_i(clear_b),
    .s_o    (Sb),
    .count_o(count_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench: a level-mode and a sticky-mode conditioner share stimulus and are
// checked against hand-computed expectations.
module tb_traffic_sensor_conditioner;

  logic       clk;
  logic       reset_n;
  logic       sa_raw, sb_raw, clear_a, clear_b;
  logic       sa_l, sb_l, sa_s, sb_s;
  logic [7:0] cnta_l, cntb_l, cnta_s, cntb_s;

  int total;
  int bad;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .LATCH_MODE     (0),
    .COUNT_W        (8)
  ) dut_lvl (
    .clk    (clk),
    .reset_n(reset_n),
    .sa_raw (sa_raw),
    .sb_raw (sb_raw),
    .clear_a(clear_a),
    .clear_b(clear_b),
    .Sa     (sa_l),
    .Sb     (sb_l),
    .count_a(cnta_l),
    .count_b(cntb_l)
  );

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .LATCH_MODE     (1),
    .COUNT_W        (8)
  ) dut_stk (
    .clk    (clk),
    .reset_n(reset_n),
    .sa_raw (sa_raw),
    .sb_raw (sb_raw),
    .clear_a(clear_a),
    .clear_b(clear_b),
    .Sa     (sa_s),
    .Sb     (sb_s),
    .count_a(cnta_s),
    .count_b(cntb_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic sa, sb, ca, cb;
    int   edges;
    logic sa_l, sb_l, sa_s, sb_s;
    int   cnt_a, cnt_b;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic el_a, input logic el_b,
                           input logic es_a, input logic es_b, input int ea, input int eb);
    check({tag, " Sa lvl"}, 32'(sa_l), 32'(el_a));
    check({tag, " Sb lvl"}, 32'(sb_l), 32'(el_b));
    check({tag, " Sa stk"}, 32'(sa_s), 32'(es_a));
    check({tag, " Sb stk"}, 32'(sb_s), 32'(es_b));
    check({tag, " count_a lvl"}, 32'(cnta_l), 32'(ea));
    check({tag, " count_b lvl"}, 32'(cntb_l), 32'(eb));
    check({tag, " count_a stk"}, 32'(cnta_s), 32'(ea));
    check({tag, " count_b stk"}, 32'(cntb_s), 32'(eb));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    sa_raw  = 1'b0;
    sb_raw  = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;

    //         sa sb ca cb edges  Sa_l Sb_l Sa_s Sb_s  cnt_a cnt_b
    vecs[0]  = '{1, 0, 0, 0, 17,  0, 0, 0, 0,  0, 0};  // one edge short of latency
    vecs[1]  = '{1, 0, 0, 0, 1,   1, 0, 1, 0,  1, 0};  // 18th edge: rise
    vecs[2]  = '{0, 0, 0, 0, 17,  1, 0, 1, 0,  1, 0};
    vecs[3]  = '{0, 0, 0, 0, 1,   0, 0, 1, 0,  1, 0};  // sticky survives fall
    vecs[4]  = '{0, 0, 1, 0, 1,   0, 0, 0, 0,  1, 0};  // clear_a one cycle
    vecs[5]  = '{0, 1, 0, 0, 15,  0, 0, 0, 0,  1, 0};  // 15-cycle glitch on B
    vecs[6]  = '{0, 0, 0, 0, 5,   0, 0, 0, 0,  1, 0};
    vecs[7]  = '{0, 1, 0, 0, 17,  0, 0, 0, 0,  1, 0};
    vecs[8]  = '{0, 1, 0, 0, 1,   0, 1, 0, 1,  1, 1};
    vecs[9]  = '{1, 0, 0, 0, 17,  0, 1, 0, 1,  1, 1};  // A rises while B falls
    vecs[10] = '{1, 0, 0, 0, 1,   1, 0, 1, 1,  2, 1};
    vecs[11] = '{1, 0, 0, 1, 1,   1, 0, 1, 0,  2, 1};  // clear_b only
    vecs[12] = '{0, 0, 0, 0, 18,  0, 0, 1, 0,  2, 1};
    vecs[13] = '{0, 0, 1, 0, 1,   0, 0, 0, 0,  2, 1};
    vecs[14] = '{1, 0, 0, 0, 17,  0, 0, 0, 0,  2, 1};
    vecs[15] = '{1, 0, 1, 0, 1,   1, 0, 0, 0,  3, 1};  // clear coincides with rise
    vecs[16] = '{1, 0, 0, 0, 1,   1, 0, 0, 0,  3, 1};

    run(3);
    check_all("in reset", 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    run(2);
    check_all("idle", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      sa_raw  = vecs[i].sa;
      sb_raw  = vecs[i].sb;
      clear_a = vecs[i].ca;
      clear_b = vecs[i].cb;
      run(vecs[i].edges);
      check_all($sformatf("row%0d", i), vecs[i].sa_l, vecs[i].sb_l, vecs[i].sa_s,
                vecs[i].sb_s, vecs[i].cnt_a, vecs[i].cnt_b);
    end
    clear_a = 1'b0;
    sa_raw  = 1'b0;
    run(20);

    // Saturation: count_a starts at 3; 260 pulses must stop at 255.
    for (int p = 0; p < 260; p++) begin
      sa_raw = 1'b1;
      run(20);
      sa_raw = 1'b0;
      run(20);
      if (p == 250) begin
        check("sat pre lvl", 32'(cnta_l), 32'd254);
        check("sat pre stk", 32'(cnta_s), 32'd254);
      end
      if (p == 251) begin
        check("sat hit lvl", 32'(cnta_l), 32'd255);
      end
    end
    check_all("saturated", 0, 0, 1, 0, 255, 1);

    // Async reset mid-debounce (cnt = 10), then restart with raw still high.
    sa_raw = 1'b1;
    run(12);
    #2 reset_n = 1'b0;
    #1;
    check_all("async rst", 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    run(17);
    check_all("post rst 17", 0, 0, 0, 0, 0, 0);
    run(1);
    check_all("post rst 18", 1, 0, 1, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
